host_mem_rdwr_responder: RTL and testbench

Avalon-MM split read/write sink that terminates a host-memory-style rd/wr channel pair (the same channel shape the AFU drives toward host memory) with an on-chip RAM. It serves DMA and kernel-USM traffic for hardware loopback and board bring-up without a host. It accepts one read burst and one write burst concurrently, returns read data in order, and issues one write response per write burst.

---
 rtl/host_mem_resp_pkg.sv | 16 +
 rtl/host_mem_resp_sdp_ram.sv | 32 +++
 rtl/host_mem_rdwr_responder.sv | 185 ++++++++++++++++++
 tb/tb_host_mem_rdwr_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/host_mem_resp_pkg.sv
// Shared types and constants for the host-memory rd/wr responder.
// Holds the channel FSM encodings, read pipeline depth and burstcount normalisation.
package host_mem_resp_pkg;

    typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;
    typedef enum logic {WR_IDLE, WR_BURST} wr_state_t;

    // RAM read register plus output register.
    localparam int RD_LATENCY = 2;

    // A zero burstcount is served as a single beat.
    function automatic int unsigned burst_beats(input int unsigned count);
        return (count == 0) ? 1 : count;
    endfunction

endpackage

// File: rtl/host_mem_resp_sdp_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
// 1-cycle read latency; a same-cycle read of the line being written returns the old contents.
module host_mem_resp_sdp_ram #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/host_mem_rdwr_responder.sv
// Avalon-MM rd/wr burst sink backed by on-chip RAM; read data 2 cycles after issue, write response 1 cycle after last beat.
// Read channel stalls during a burst; write channel never stalls once out of reset.
module host_mem_rdwr_responder
    import host_mem_resp_pkg::*;
#(
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int ADDR_WIDTH      = 48,
    parameter int MEM_ADDR_WIDTH  = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_WIDTH-1:0]      rd_address,
    input  logic                       rd_read,
    input  logic [BURST_CNT_WIDTH-1:0] rd_burstcount,
    output logic                       rd_waitrequest,
    output logic [DATA_WIDTH-1:0]      rd_readdata,
    output logic                       rd_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]      wr_address,
    input  logic                       wr_write,
    input  logic [BURST_CNT_WIDTH-1:0] wr_burstcount,
    input  logic [DATA_WIDTH-1:0]      wr_writedata,
    input  logic [DATA_WIDTH/8-1:0]    wr_byteenable,
    output logic                       wr_waitrequest,
    output logic                       wr_writeresponsevalid,
    output logic                       protocol_err
);

    localparam logic [BURST_CNT_WIDTH-1:0] CNT_ONE  = BURST_CNT_WIDTH'(1);
    localparam logic [MEM_ADDR_WIDTH-1:0]  ADDR_ONE = MEM_ADDR_WIDTH'(1);

    logic [1:0] rst_sync;
    logic       ready;

    // Reset asserts immediately; release reaches the FSMs through two flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign ready = rst_sync[1];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_address[ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                                wr_address[ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

    // ---------------- read channel ----------------
    rd_state_t                  rd_state, rd_state_nxt;
    logic [MEM_ADDR_WIDTH-1:0]  rd_addr_q, rd_ram_addr;
    logic [BURST_CNT_WIDTH-1:0] rd_remaining, rd_beats;
    logic                       rd_issue;
    logic [RD_LATENCY-1:0]      rd_vld_pipe;
    logic [DATA_WIDTH-1:0]      ram_rd_data;

    assign rd_beats = BURST_CNT_WIDTH'(burst_beats(32'(rd_burstcount)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_state <= RD_IDLE;
        else          rd_state <= rd_state_nxt;
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            RD_IDLE:  if (ready && rd_read && rd_beats > CNT_ONE) rd_state_nxt = RD_BURST;
            RD_BURST: if (rd_remaining == CNT_ONE) rd_state_nxt = RD_IDLE;
            default:  rd_state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_waitrequest = 1'b1;
        rd_issue       = 1'b0;
        rd_ram_addr    = rd_addr_q;
        case (rd_state)
            RD_IDLE: begin
                rd_waitrequest = !ready;
                rd_issue       = ready && rd_read;
                rd_ram_addr    = rd_address[MEM_ADDR_WIDTH-1:0];
            end
            RD_BURST: rd_issue = 1'b1;
            default:  rd_issue = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr_q    <= '0;
            rd_remaining <= '0;
        end else if (rd_issue) begin
            rd_addr_q    <= rd_ram_addr + ADDR_ONE;
            rd_remaining <= (rd_state == RD_IDLE) ? rd_beats - CNT_ONE : rd_remaining - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_pipe <= '0;
            rd_readdata <= '0;
        end else begin
            rd_vld_pipe <= {rd_vld_pipe[RD_LATENCY-2:0], rd_issue};
            if (rd_vld_pipe[0]) rd_readdata <= ram_rd_data;
        end
    end
    assign rd_readdatavalid = rd_vld_pipe[RD_LATENCY-1];

    // ---------------- write channel ----------------
    wr_state_t                  wr_state, wr_state_nxt;
    logic [MEM_ADDR_WIDTH-1:0]  wr_addr_q, wr_ram_addr;
    logic [BURST_CNT_WIDTH-1:0] wr_remaining, wr_beats;
    logic                       wr_en, wr_last;

    assign wr_beats = BURST_CNT_WIDTH'(burst_beats(32'(wr_burstcount)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wr_state <= WR_IDLE;
        else          wr_state <= wr_state_nxt;
    end

    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            WR_IDLE:  if (ready && wr_write && wr_beats > CNT_ONE) wr_state_nxt = WR_BURST;
            WR_BURST: if (wr_write && wr_remaining == CNT_ONE) wr_state_nxt = WR_IDLE;
            default:  wr_state_nxt = WR_IDLE;
        endcase
    end

    always_comb begin
        wr_waitrequest = !ready;
        wr_en          = 1'b0;
        wr_last        = 1'b0;
        wr_ram_addr    = wr_addr_q;
        case (wr_state)
            WR_IDLE: begin
                wr_en       = ready && wr_write;
                wr_last     = wr_en && (wr_beats == CNT_ONE);
                wr_ram_addr = wr_address[MEM_ADDR_WIDTH-1:0];
            end
            WR_BURST: begin
                wr_en   = wr_write;
                wr_last = wr_write && (wr_remaining == CNT_ONE);
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_addr_q             <= '0;
            wr_remaining          <= '0;
            wr_writeresponsevalid <= 1'b0;
        end else begin
            wr_writeresponsevalid <= wr_last;
            if (wr_en) begin
                wr_addr_q    <= wr_ram_addr + ADDR_ONE;
                wr_remaining <= (wr_state == WR_IDLE) ? wr_beats - CNT_ONE : wr_remaining - CNT_ONE;
            end
        end
    end

    // Only command-carrying cycles see a meaningful burstcount.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            protocol_err <= 1'b0;
        end else if ((rd_state == RD_IDLE && rd_issue && rd_burstcount == '0) ||
                     (wr_state == WR_IDLE && wr_en && wr_burstcount == '0)) begin
            protocol_err <= 1'b1;
        end
    end

    host_mem_resp_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ram_addr),
        .wr_data (wr_writedata),
        .wr_be   (wr_byteenable),
        .rd_en   (rd_issue),
        .rd_addr (rd_ram_addr),
        .rd_data (ram_rd_data)
    );

endmodule

// File: tb/tb_host_mem_rdwr_responder.sv
// Directed bench for host_mem_rdwr_responder: bursts, wrap/alias, byte enables, concurrency, zero burst, reset abort.
module tb_host_mem_rdwr_responder;

    logic         clk;
    logic         reset_n;
    logic [47:0]  rd_address;
    logic         rd_read;
    logic [6:0]   rd_burstcount;
    logic         rd_waitrequest;
    logic [511:0] rd_readdata;
    logic         rd_readdatavalid;
    logic [47:0]  wr_address;
    logic         wr_write;
    logic [6:0]   wr_burstcount;
    logic [511:0] wr_writedata;
    logic [63:0]  wr_byteenable;
    logic         wr_waitrequest;
    logic         wr_writeresponsevalid;
    logic         protocol_err;

    int n_checks = 0;
    int n_fail   = 0;

    host_mem_rdwr_responder dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .rd_address            (rd_address),
        .rd_read               (rd_read),
        .rd_burstcount         (rd_burstcount),
        .rd_waitrequest        (rd_waitrequest),
        .rd_readdata           (rd_readdata),
        .rd_readdatavalid      (rd_readdatavalid),
        .wr_address            (wr_address),
        .wr_write              (wr_write),
        .wr_burstcount         (wr_burstcount),
        .wr_writedata          (wr_writedata),
        .wr_byteenable         (wr_byteenable),
        .wr_waitrequest        (wr_waitrequest),
        .wr_writeresponsevalid (wr_writeresponsevalid),
        .protocol_err          (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one read command and check every beat lands at its exact cycle.
    task automatic rd_burst(input logic [47:0] addr, input logic [6:0] bc, input int beats,
                            input logic [511:0] base, input string tag);
        rd_address    = addr;
        rd_burstcount = bc;
        rd_read       = 1'b1;
        tick;
        rd_read       = 1'b0;
        rd_address    = '0;
        rd_burstcount = '0;
        chk($sformatf("%s_wait", tag), rd_waitrequest, beats > 1);
        chk($sformatf("%s_early", tag), rd_readdatavalid, 1'b0);
        for (int i = 0; i < beats; i++) begin
            tick;
            chk($sformatf("%s_vld%0d", tag, i), rd_readdatavalid, 1'b1);
            chk($sformatf("%s_dat%0d", tag, i), rd_readdata, base + 512'(i));
        end
        tick;
        chk($sformatf("%s_tail", tag), rd_readdatavalid, 1'b0);
    endtask

    // Write a burst of base+i; optional idle cycle after beat 0; later beats carry junk address/count.
    task automatic wr_burst(input logic [47:0] addr, input logic [6:0] bc, input int beats,
                            input logic [511:0] base, input logic [63:0] be, input bit gap,
                            input string tag);
        for (int i = 0; i < beats; i++) begin
            wr_write      = 1'b1;
            wr_writedata  = base + 512'(i);
            wr_byteenable = be;
            wr_address    = (i == 0) ? addr : ~addr;
            wr_burstcount = (i == 0) ? bc : 7'h7f;
            tick;
            if (i < beats - 1) chk($sformatf("%s_resp_early%0d", tag, i), wr_writeresponsevalid, 1'b0);
            if (gap && i == 0 && beats > 1) begin
                wr_write = 1'b0;
                tick;
                chk($sformatf("%s_resp_gap", tag), wr_writeresponsevalid, 1'b0);
            end
        end
        wr_write = 1'b0;
        chk($sformatf("%s_resp", tag), wr_writeresponsevalid, 1'b1);
        tick;
        chk($sformatf("%s_resp_end", tag), wr_writeresponsevalid, 1'b0);
    endtask

    logic [63:0]  be_all;
    logic [511:0] ones;
    logic [511:0] byte0_clr;

    initial begin
        be_all    = '1;
        ones      = '1;
        byte0_clr = {{504{1'b1}}, 8'h00};

        reset_n = 1'b0;
        rd_address = '0; rd_read = 1'b0; rd_burstcount = '0;
        wr_address = '0; wr_write = 1'b0; wr_burstcount = '0;
        wr_writedata = '0; wr_byteenable = '0;
        repeat (3) tick;
        chk("rst_rd_wait", rd_waitrequest, 1'b1);
        chk("rst_wr_wait", wr_waitrequest, 1'b1);
        chk("rst_rd_vld", rd_readdatavalid, 1'b0);
        chk("rst_wr_resp", wr_writeresponsevalid, 1'b0);
        chk("rst_perr", protocol_err, 1'b0);
        chk("rst_rd_dat", rd_readdata, 512'h0);

        reset_n = 1'b1;
        tick;
        chk("rel1_rd_wait", rd_waitrequest, 1'b1);
        chk("rel1_wr_wait", wr_waitrequest, 1'b1);
        tick;
        chk("rel2_rd_wait", rd_waitrequest, 1'b0);
        chk("rel2_wr_wait", wr_waitrequest, 1'b0);

        // 4-beat write with an idle cycle inside the burst, then read back
        wr_burst(48'h10, 7'd4, 4, 512'hA0, be_all, 1'b1, "wr4");
        rd_burst(48'h10, 7'd4, 4, 512'hA0, "rd4");

        // byte enables
        wr_burst(48'h5, 7'd1, 1, ones, be_all, 1'b0, "be_set");
        wr_burst(48'h5, 7'd1, 1, 512'h0, 64'h1, 1'b0, "be_clr");
        rd_burst(48'h5, 7'd1, 1, byte0_clr, "be_rd");

        // wrap across the top of the RAM, then upper-address aliasing
        wr_burst(48'h3FF, 7'd3, 3, 512'hB0, be_all, 1'b0, "wrap_wr");
        rd_burst(48'h3FF, 7'd3, 3, 512'hB0, "wrap_rd");
        rd_burst(48'h000, 7'd1, 1, 512'hB1, "wrap_l0");
        rd_burst(48'h001, 7'd1, 1, 512'hB2, "wrap_l1");
        wr_burst(48'h0FF, 7'd1, 1, 512'hC5, be_all, 1'b0, "alias_wr");
        rd_burst(48'h4FF, 7'd1, 1, 512'hC5, "alias_rd");

        // same-line collision: same cycle gives old data, next cycle gives new
        wr_burst(48'h20, 7'd1, 1, 512'h01, be_all, 1'b0, "col_init");
        wr_address = 48'h20; wr_burstcount = 7'd1; wr_writedata = 512'h02;
        wr_byteenable = be_all; wr_write = 1'b1;
        rd_address = 48'h20; rd_burstcount = 7'd1; rd_read = 1'b1;
        tick;
        wr_write = 1'b0;
        chk("col_resp", wr_writeresponsevalid, 1'b1);
        tick;
        rd_read = 1'b0;
        chk("col_old_vld", rd_readdatavalid, 1'b1);
        chk("col_old_dat", rd_readdata, 512'h01);
        tick;
        chk("col_new_vld", rd_readdatavalid, 1'b1);
        chk("col_new_dat", rd_readdata, 512'h02);
        tick;
        chk("col_tail", rd_readdatavalid, 1'b0);

        // concurrent 64-beat read and write to disjoint lines
        chk("perr_pre", protocol_err, 1'b0);
        wr_burst(48'h100, 7'd64, 64, 512'h1000, be_all, 1'b0, "cc_init");
        fork
            rd_burst(48'h100, 7'd64, 64, 512'h1000, "cc_rd");
            wr_burst(48'h200, 7'd64, 64, 512'h2000, be_all, 1'b0, "cc_wr");
        join
        rd_burst(48'h200, 7'd64, 64, 512'h2000, "cc_chk");

        // zero burstcount: one beat, sticky error
        rd_burst(48'h10, 7'd0, 1, 512'hA0, "rd0");
        chk("perr_set", protocol_err, 1'b1);
        rd_burst(48'h11, 7'd1, 1, 512'hA1, "rd_after0");
        chk("perr_sticky", protocol_err, 1'b1);

        // reset in the middle of an 8-beat read
        wr_burst(48'h40, 7'd8, 8, 512'hD0, be_all, 1'b0, "rst_wr");
        rd_address = 48'h40; rd_burstcount = 7'd8; rd_read = 1'b1;
        tick;
        rd_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("ab_vld%0d", i), rd_readdatavalid, 1'b1);
            chk($sformatf("ab_dat%0d", i), rd_readdata, 512'hD0 + 512'(i));
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("ab_async_vld", rd_readdatavalid, 1'b0);
        chk("ab_async_wait", rd_waitrequest, 1'b1);
        chk("ab_async_perr", protocol_err, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("ab_hold%0d", i), rd_readdatavalid, 1'b0);
        end
        reset_n = 1'b1;
        tick;
        chk("ab_rel1_wait", rd_waitrequest, 1'b1);
        chk("ab_rel1_vld", rd_readdatavalid, 1'b0);
        tick;
        chk("ab_rel2_wait", rd_waitrequest, 1'b0);
        chk("ab_rel2_vld", rd_readdatavalid, 1'b0);
        chk("ab_rel2_resp", wr_writeresponsevalid, 1'b0);
        rd_burst(48'h40, 7'd8, 8, 512'hD0, "ab_rd");
        rd_burst(48'h10, 7'd1, 1, 512'hA0, "ab_keep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
